// File: rtl/capture_pkg.sv
// capture_pkg: shared types and constants for the capture controller.
//   cap_state_t  acquisition FSM state encoding
//   ADDR_W_DEF   default sample RAM address width
package capture_pkg;

  localparam int ADDR_W_DEF = 19;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } cap_state_t;

endpackage

// File: rtl/capture_ctrl_if.sv
// capture_ctrl_if: sample RAM write port (wrclock is the controller clock).
//   wren       write enable, one cycle per stored sample
//   wraddress  write address
//   data       sample bit
// modport master: the controller driving the port; slave: the RAM side.
interface capture_ctrl_if #(
  parameter int ADDR_W = capture_pkg::ADDR_W_DEF
);

  logic              wren;
  logic [ADDR_W-1:0] wraddress;
  logic              data;

  modport master (output wren, output wraddress, output data);
  modport slave  (input  wren, input  wraddress, input  data);

endinterface

// File: rtl/capture_ctrl.sv
// capture_ctrl: pre/post-trigger acquisition into a circular 1-bit sample RAM.
// Ports:
//   sys_clk, sys_rst_n     clock (also RAM wrclock), async active-low reset
//   arm, abort             one-cycle start / cancel pulses (abort wins)
//   sample_en, sample_in   sample strobe and sample bit
//   trig                   trigger flag, qualified by sample_en
//   pre_len, rec_len       pre-trigger length and total record length (samples)
//   ram                    RAM write port (wren, wraddress, data)
//   busy, done             acquisition active / record complete
//   trig_addr, start_addr  trigger sample address / oldest sample address
//
// state | meaning
// IDLE  | no acquisition, waiting for arm
// PRE   | filling the pre-trigger window, trig ignored
// ARMED | writing circularly, waiting for a qualified trig
// POST  | writing the samples that follow the trigger
// DONE  | record complete, results held until the next arm
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              arm,
  input  logic              abort,
  input  logic              sample_en,
  input  logic              sample_in,
  input  logic              trig,
  input  logic [ADDR_W-1:0] pre_len,
  input  logic [ADDR_W-1:0] rec_len,
  capture_ctrl_if.master    ram,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] start_addr
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  cap_state_t        state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] rec_len_q;
  logic [ADDR_W-1:0] pre_eff_q;
  logic              fin, fin_nxt;

  logic              smp;
  logic              arm_ok;
  logic              trig_hit;
  logic              cnt_dec;
  logic [ADDR_W-1:0] rec_len_m1;
  logic [ADDR_W-1:0] pre_eff_in;
  logic [ADDR_W-1:0] post_rem;

  always_comb begin
    smp        = 1'b0;
    arm_ok     = 1'b0;
    trig_hit   = 1'b0;
    cnt_dec    = 1'b0;
    fin_nxt    = 1'b0;
    state_nxt  = state;
    rec_len_m1 = rec_len - ONE;
    // at least one sample must remain for the trigger itself
    pre_eff_in = (pre_len > rec_len_m1) ? rec_len_m1 : pre_len;
    // samples still to come after the trigger sample
    post_rem   = rec_len_q - pre_eff_q - ONE;

    smp    = sample_en && (state == PRE || state == ARMED || state == POST);
    arm_ok = arm && (rec_len != '0) && (state == IDLE || state == DONE);

    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (arm_ok) state_nxt = (pre_eff_in == '0) ? ARMED : PRE;
        end
        PRE: begin
          cnt_dec = sample_en;
          if (sample_en && cnt == ONE) state_nxt = ARMED;
        end
        ARMED: begin
          if (sample_en && trig) begin
            trig_hit = 1'b1;
            if (post_rem == '0) begin
              state_nxt = DONE;
              fin_nxt   = 1'b1;
            end else begin
              state_nxt = POST;
            end
          end
        end
        POST: begin
          cnt_dec = sample_en;
          if (sample_en && cnt == ONE) begin
            state_nxt = DONE;
            fin_nxt   = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // fin marks the cycle in which the last write is on the RAM port; done and
  // start_addr follow one cycle later.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= IDLE;
      fin           <= 1'b0;
      ptr           <= '0;
      cnt           <= '0;
      rec_len_q     <= '0;
      pre_eff_q     <= '0;
      ram.wren      <= 1'b0;
      ram.wraddress <= '0;
      ram.data      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      trig_addr     <= '0;
      start_addr    <= '0;
    end else begin
      state    <= state_nxt;
      fin      <= fin_nxt;
      ram.wren <= smp && !abort;
      if (smp) begin
        ram.wraddress <= ptr;
        ram.data      <= sample_in;
        ptr           <= ptr + ONE;
      end
      if (abort) begin
        busy <= 1'b0;
        done <= 1'b0;
      end else if (arm_ok) begin
        rec_len_q <= rec_len;
        pre_eff_q <= pre_eff_in;
        cnt       <= pre_eff_in;
        ptr       <= '0;
        busy      <= 1'b1;
        done      <= 1'b0;
      end else begin
        if (cnt_dec) cnt <= cnt - ONE;
        if (trig_hit) begin
          trig_addr <= ptr;
          cnt       <= post_rem;
        end
        if (fin) begin
          done       <= 1'b1;
          busy       <= 1'b0;
          start_addr <= trig_addr - pre_eff_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
module tb_capture_ctrl;
  import capture_pkg::*;

  typedef struct {
    logic [18:0] addr;
    logic        d;
  } wr_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        arm = 1'b0, abort = 1'b0, sample_en = 1'b0, sample_in = 1'b0, trig = 1'b0;
  logic [18:0] pre_len = '0, rec_len = '0;
  logic [3:0]  pre_len4 = '0, rec_len4 = '0;
  logic        busy, done, busy4, done4;
  logic [18:0] trig_addr, start_addr;
  logic [3:0]  trig_addr4, start_addr4;

  int          checks = 0;
  int          errors = 0;
  wr_t         exp_q[$];
  logic [18:0] exp_ptr = '0;
  logic [18:0] amask = 19'h7FFFF;
  bit          sel4 = 1'b0;
  int          wr_count = 0;
  logic [18:0] last_addr = '0;

  capture_ctrl_if #(.ADDR_W(19)) ram ();
  capture_ctrl_if #(.ADDR_W(4))  ram4 ();

  capture_ctrl #(.ADDR_W(19)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .arm(arm), .abort(abort),
    .sample_en(sample_en), .sample_in(sample_in), .trig(trig),
    .pre_len(pre_len), .rec_len(rec_len), .ram(ram),
    .busy(busy), .done(done), .trig_addr(trig_addr), .start_addr(start_addr)
  );

  capture_ctrl #(.ADDR_W(4)) dut4 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .arm(arm), .abort(abort),
    .sample_en(sample_en), .sample_in(sample_in), .trig(trig),
    .pre_len(pre_len4), .rec_len(rec_len4), .ram(ram4),
    .busy(busy4), .done(done4), .trig_addr(trig_addr4), .start_addr(start_addr4)
  );

  always #5 sys_clk = ~sys_clk;

  // write monitor: pops the scoreboard on every observed write
  always @(negedge sys_clk) begin
    logic        w;
    logic [18:0] a;
    logic        d;
    wr_t         e;
    w = sel4 ? ram4.wren : ram.wren;
    a = sel4 ? {15'd0, ram4.wraddress} : ram.wraddress;
    d = sel4 ? ram4.data : ram.data;
    if (w === 1'b1) begin
      checks++;
      wr_count++;
      last_addr = a;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0d data=%0b", a, d);
      end else begin
        e = exp_q.pop_front();
        if (a !== e.addr || d !== e.d) begin
          errors++;
          $display("FAIL write got addr=%0d data=%0b expected addr=%0d data=%0b",
                   a, d, e.addr, e.d);
        end
      end
    end
  end

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic do_arm();
    arm = 1'b1;
    @(posedge sys_clk);
    #1;
    arm = 1'b0;
    exp_ptr = '0;
  endtask

  task automatic smp(input logic b, input logic tg, input bit exp_wr);
    sample_en = 1'b1;
    sample_in = b;
    trig      = tg;
    if (exp_wr) begin
      exp_q.push_back('{addr: exp_ptr, d: b});
      exp_ptr = (exp_ptr + 19'd1) & amask;
    end
    @(posedge sys_clk);
    #1;
    sample_en = 1'b0;
    sample_in = 1'b0;
    trig      = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    checks++;
    if (ram.wren !== 1'b0 || ram.wraddress !== '0 || ram.data !== 1'b0) begin
      errors++;
      $display("FAIL reset_ram wren=%0b addr=%0d data=%0b expected 0/0/0",
               ram.wren, ram.wraddress, ram.data);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_status busy=%0b done=%0b expected 0/0", busy, done);
    end
    checks++;
    if (trig_addr !== '0 || start_addr !== '0) begin
      errors++;
      $display("FAIL reset_addr trig=%0d start=%0d expected 0/0", trig_addr, start_addr);
    end
    sys_rst_n = 1'b1;
    gap(2);
    checks++;
    if (busy !== 1'b0 || ram.wren !== 1'b0) begin
      errors++;
      $display("FAIL reset_release busy=%0b wren=%0b expected 0/0", busy, ram.wren);
    end
  endtask

  task automatic test_basic(input bit trig_pre);
    pre_len = 19'd4; rec_len = 19'd10; rec_len4 = '0;
    wr_count = 0;
    do_arm();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL basic_arm busy=%0b done=%0b expected 1/0", busy, done);
    end
    for (int i = 0; i < 13; i++)
      smp(1'($urandom_range(0, 1)), (i == 7) || (trig_pre && i == 2), 1'b1);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_last_write_cycle done=%0b busy=%0b expected 0/1", done, busy);
    end
    gap(1);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done done=%0b busy=%0b expected 1/0", done, busy);
    end
    checks++;
    if (trig_addr !== 19'd7 || start_addr !== 19'd3) begin
      errors++;
      $display("FAIL basic_addr trig=%0d start=%0d expected 7/3", trig_addr, start_addr);
    end
    checks++;
    if (wr_count !== 13 || last_addr !== 19'd12) begin
      errors++;
      $display("FAIL basic_writes count=%0d last=%0d expected 13/12", wr_count, last_addr);
    end
    gap(3);
    checks++;
    if (done !== 1'b1 || trig_addr !== 19'd7 || start_addr !== 19'd3 || ram.wren !== 1'b0) begin
      errors++;
      $display("FAIL basic_hold done=%0b trig=%0d start=%0d wren=%0b expected 1/7/3/0",
               done, trig_addr, start_addr, ram.wren);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_missing_writes left=%0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_wrap4();
    sel4 = 1'b1; amask = 19'h0000F;
    rec_len = '0; pre_len4 = 4'd5; rec_len4 = 4'd8;
    wr_count = 0;
    do_arm();
    checks++;
    if (busy4 !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wrap_arm busy4=%0b busy=%0b expected 1/0", busy4, busy);
    end
    for (int i = 0; i < 21; i++) smp(1'($urandom_range(0, 1)), i == 18, 1'b1);
    gap(1);
    checks++;
    if (done4 !== 1'b1 || trig_addr4 !== 4'd2 || start_addr4 !== 4'd13) begin
      errors++;
      $display("FAIL wrap_result done=%0b trig=%0d start=%0d expected 1/2/13",
               done4, trig_addr4, start_addr4);
    end
    checks++;
    if (wr_count !== 21 || last_addr !== 19'd4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_writes count=%0d last=%0d left=%0d expected 21/4/0",
               wr_count, last_addr, exp_q.size());
    end
    rec_len4 = '0;
    sel4 = 1'b0; amask = 19'h7FFFF;
  endtask

  task automatic test_sparse();
    pre_len = 19'd2; rec_len = 19'd5;
    do_arm();
    for (int i = 0; i < 6; i++) begin
      smp(1'($urandom_range(0, 1)), i == 3, 1'b1);
      checks++;
      if (ram.wren !== 1'b1 || ram.wraddress !== 19'(i)) begin
        errors++;
        $display("FAIL sparse_strobe wren=%0b addr=%0d expected 1/%0d", ram.wren, ram.wraddress, i);
      end
      gap(1);
      checks++;
      if (ram.wren !== 1'b0) begin
        errors++;
        $display("FAIL sparse_gap wren=%0b expected 0", ram.wren);
      end
      gap(1);
    end
    checks++;
    if (done !== 1'b1 || trig_addr !== 19'd3 || start_addr !== 19'd1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL sparse_result done=%0b trig=%0d start=%0d left=%0d expected 1/3/1/0",
               done, trig_addr, start_addr, exp_q.size());
    end
  endtask

  task automatic test_abort();
    pre_len = 19'd2; rec_len = 19'd10;
    do_arm();
    for (int i = 0; i < 5; i++) smp(1'b1, i == 3, 1'b1);
    abort = 1'b1; arm = 1'b1; sample_en = 1'b1; sample_in = 1'b1;
    @(posedge sys_clk);
    #1;
    abort = 1'b0; arm = 1'b0; sample_en = 1'b0; sample_in = 1'b0;
    checks++;
    if (ram.wren !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_cycle wren=%0b busy=%0b done=%0b expected 0/0/0", ram.wren, busy, done);
    end
    gap(2);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_wins_over_arm busy=%0b expected 0", busy);
    end
    pre_len = 19'd0; rec_len = 19'd3;
    wr_count = 0;
    do_arm();
    for (int i = 0; i < 3; i++) smp(1'($urandom_range(0, 1)), i == 0, 1'b1);
    gap(1);
    checks++;
    if (done !== 1'b1 || trig_addr !== 19'd0 || start_addr !== 19'd0 || last_addr !== 19'd2
        || exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_restart done=%0b trig=%0d start=%0d last=%0d left=%0d expected 1/0/0/2/0",
               done, trig_addr, start_addr, last_addr, exp_q.size());
    end
  endtask

  task automatic test_reset_armed();
    pre_len = 19'd1; rec_len = 19'd4;
    do_arm();
    for (int i = 0; i < 3; i++) smp(1'b1, 1'b0, 1'b1);
    gap(1);
    sample_en = 1'b1; sample_in = 1'b1; sys_rst_n = 1'b0;
    #2;
    checks++;
    if (ram.wren !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || trig_addr !== '0) begin
      errors++;
      $display("FAIL rst_async wren=%0b busy=%0b done=%0b trig=%0d expected 0/0/0/0",
               ram.wren, busy, done, trig_addr);
    end
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    checks++;
    if (ram.wren !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_release_write wren=%0b busy=%0b expected 0/0", ram.wren, busy);
    end
    sample_en = 1'b0; sample_in = 1'b0;
    pre_len = 19'd1; rec_len = 19'd2;
    wr_count = 0;
    do_arm();
    smp(1'b0, 1'b1, 1'b1);
    smp(1'b1, 1'b1, 1'b1);
    gap(1);
    checks++;
    if (done !== 1'b1 || trig_addr !== 19'd1 || start_addr !== 19'd0 || wr_count !== 2
        || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rst_restart done=%0b trig=%0d start=%0d count=%0d left=%0d expected 1/1/0/2/0",
               done, trig_addr, start_addr, wr_count, exp_q.size());
    end
  endtask

  task automatic test_zero_len();
    pre_len = 19'd3; rec_len = 19'd0;
    wr_count = 0;
    do_arm();
    checks++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL zero_len_arm busy=%0b done=%0b expected 0/1", busy, done);
    end
    for (int i = 0; i < 5; i++) smp(1'b1, 1'b1, 1'b0);
    gap(2);
    checks++;
    if (busy !== 1'b0 || wr_count !== 0) begin
      errors++;
      $display("FAIL zero_len_writes busy=%0b count=%0d expected 0/0", busy, wr_count);
    end
  endtask

  task automatic test_pre_clamp();
    pre_len = 19'd12; rec_len = 19'd10;
    wr_count = 0;
    do_arm();
    for (int i = 0; i < 12; i++) smp(1'($urandom_range(0, 1)), (i == 5) || (i == 11), 1'b1);
    gap(1);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || trig_addr !== 19'd11 || start_addr !== 19'd2) begin
      errors++;
      $display("FAIL clamp_result done=%0b busy=%0b trig=%0d start=%0d expected 1/0/11/2",
               done, busy, trig_addr, start_addr);
    end
    checks++;
    if (wr_count !== 12 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL clamp_writes count=%0d left=%0d expected 12/0", wr_count, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic(1'b0);
    test_basic(1'b1);
    test_wrap4();
    test_sparse();
    test_abort();
    test_reset_armed();
    test_zero_len();
    test_pre_clamp();
    gap(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
